// File: rtl/pattern_loader_if.sv
// Host-side byte stream into the loader and readback stream out of it.
interface pattern_loader_if #(
  parameter int unsigned buffer_width = 8
);
  logic [buffer_width-1:0] load_byte;
  logic                    load_valid;
  logic                    load_ready;
  logic [buffer_width-1:0] rb_byte;
  logic                    rb_valid;

  modport master (
    output load_byte,
    output load_valid,
    input  load_ready,
    input  rb_byte,
    input  rb_valid
  );

  modport slave (
    input  load_byte,
    input  load_valid,
    output load_ready,
    output rb_byte,
    output rb_valid
  );
endinterface

// File: rtl/pattern_loader.sv
// Serial driver for the pattern buffer scan chain: shifts host bytes in
// MSB-first and captures the displaced bytes as readback.
module pattern_loader #(
  parameter int unsigned buffer_width = 8,
  parameter int unsigned buffer_size  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  pattern_loader_if.slave host,
  output logic            ssel,
  output logic            sin,
  input  logic            sout,
  output logic            busy,
  output logic            done
);

  localparam int unsigned BIT_W  = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam int unsigned BYTE_W = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(buffer_width - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(buffer_size - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [buffer_width-1:0] tx_sh_q, tx_sh_d;
  logic [buffer_width-1:0] rx_sh_q, rx_sh_d;
  logic [buffer_width-1:0] rb_byte_q, rb_byte_d;
  logic                    rb_valid_q, rb_valid_d;
  logic                    ready_q, ready_d;
  logic                    ssel_q, ssel_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    xfer;

  // A byte is taken whenever the host offers it while we advertise ready.
  assign xfer = host.load_valid && ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rb_byte_d  = rb_byte_q;
    rb_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          byte_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (xfer) begin
          tx_sh_d   = host.load_byte;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tx_sh_d   = tx_sh_q << 1;
        rx_sh_d   = (rx_sh_q << 1) | buffer_width'(sout);
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          rb_byte_d  = rx_sh_d;
          rb_valid_d = 1'b1;
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          if (byte_cnt_q == BYTE_LAST) begin
            state_d = S_DONE;
          end else if (xfer) begin
            // Gapless streaming: next byte loads on the last-bit edge.
            tx_sh_d   = host.load_byte;
            bit_cnt_d = '0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready in WAIT and in the last-bit cycle of any byte but the final one.
    ready_d = (state_d == S_WAIT) ||
              ((state_d == S_SHIFT) && (bit_cnt_d == BIT_LAST) && (byte_cnt_d != BYTE_LAST));
    ssel_d  = (state_d == S_SHIFT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rb_byte_q  <= '0;
      rb_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      ssel_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rb_byte_q  <= rb_byte_d;
      rb_valid_q <= rb_valid_d;
      ready_q    <= ready_d;
      ssel_q     <= ssel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign host.load_ready = ready_q;
  assign host.rb_byte    = rb_byte_q;
  assign host.rb_valid   = rb_valid_q;
  assign ssel            = ssel_q;
  assign sin             = tx_sh_q[buffer_width-1];
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: behavioural scan-chain buffer, directed loads.
module tb_pattern_loader;

  localparam int unsigned W = 8;
  localparam int unsigned S = 32;
  localparam int unsigned N = W * S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, ssel0, sin0, sout0, busy0, done0;
  logic start1, ssel1, sin1, sout1, busy1, done1;

  pattern_loader_if #(.buffer_width(W)) ifc0 ();
  pattern_loader_if #(.buffer_width(W)) ifc1 ();

  pattern_loader #(.buffer_width(W), .buffer_size(S)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start0),
    .host  (ifc0),
    .ssel  (ssel0),
    .sin   (sin0),
    .sout  (sout0),
    .busy  (busy0),
    .done  (done0)
  );

  pattern_loader #(.buffer_width(W), .buffer_size(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .host  (ifc1),
    .ssel  (ssel1),
    .sin   (sin1),
    .sout  (sout1),
    .busy  (busy1),
    .done  (done1)
  );

  // Pattern buffer chains: sin enters entry 0 bit 0, sout is the top entry MSB.
  logic [N-1:0] chain0 = '0;
  logic [W-1:0] chain1 = '0;
  always @(posedge clk) begin
    if (ssel0 === 1'b1) chain0 <= {chain0[N-2:0], sin0};
    if (ssel1 === 1'b1) chain1 <= {chain1[W-2:0], sin1};
  end
  assign sout0 = chain0[N-1];
  assign sout1 = chain1[W-1];

  int checks   = 0;
  int failures = 0;

  // Activity monitor sampled mid-cycle.
  int         hi_cnt     = 0;
  int         gap_cnt    = 0;
  int         done_cnt   = 0;
  int         done_after = 0;
  int         rb_cnt     = 0;
  logic       seen       = 1'b0;
  logic       prev_ssel  = 1'b0;
  logic [7:0] rb_mem [1024];
  logic [7:0] sin_seq1   = '0;

  always @(negedge clk) begin
    if (ssel0 === 1'b1) hi_cnt <= hi_cnt + 1;
    if (busy0 !== 1'b1) seen <= 1'b0;
    else if (ssel0 === 1'b1) seen <= 1'b1;
    if (busy0 === 1'b1 && ssel0 === 1'b0 && seen && done0 === 1'b0) gap_cnt <= gap_cnt + 1;
    if (done0 === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (prev_ssel) done_after <= done_after + 1;
    end
    if (ifc0.rb_valid === 1'b1) begin
      rb_mem[rb_cnt % 1024] <= ifc0.rb_byte;
      rb_cnt <= rb_cnt + 1;
    end
    prev_ssel <= (ssel0 === 1'b1);
    if (ssel1 === 1'b1) sin_seq1 <= {sin_seq1[6:0], sin1};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] val(input logic [7:0] base, input bit use_xor, input int k);
    return use_xor ? (base ^ 8'(k)) : (base + 8'(k));
  endfunction

  function automatic logic [7:0] pat0(input int k);
    return chain0[k*W +: W];
  endfunction

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    ifc0.load_byte  = b;
    ifc0.load_valid = 1'b1;
    while (ifc0.load_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (ifc0.load_ready !== 1'b1) check("send_ready_timeout", 32'(ifc0.load_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Full load: supplies entry S-1 first down to entry 0, optional stall/start poke.
  task automatic do_load(input logic [7:0] base, input bit use_xor,
                         input int stall_after, input int start_at);
    int n;
    start0 = 1'b1;
    n = 0;
    while (ifc0.load_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (ifc0.load_ready !== 1'b1) check("start_timeout", 32'(ifc0.load_ready), 32'd1);
    start0 = 1'b0;
    for (int i = 0; i < int'(S); i++) begin
      if (i == start_at) start0 = 1'b1;
      send(val(base, use_xor, int'(S) - 1 - i));
      start0 = 1'b0;
      if (i == stall_after) begin
        ifc0.load_valid = 1'b0;
        n = 0;
        while (ssel0 === 1'b1 && n < 64) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        #1;
      end
    end
    ifc0.load_valid = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (done0 !== 1'b1) check("done_timeout", 32'(done0), 32'd1);
    #1;
  endtask

  task automatic check_pattern(input logic [7:0] base, input bit use_xor, input string tag);
    for (int k = 0; k < int'(S); k++)
      check($sformatf("%s_pat%0d", tag, k), 32'(pat0(k)), 32'(val(base, use_xor, k)));
  endtask

  task automatic check_rb(input logic [7:0] base, input bit use_xor, input int rb_base, input string tag);
    for (int i = 0; i < int'(S); i++)
      check($sformatf("%s_rb%0d", tag, i), 32'(rb_mem[(rb_base + i) % 1024]),
            32'(val(base, use_xor, int'(S) - 1 - i)));
  endtask

  task automatic load1(input logic [7:0] b);
    int n;
    start1 = 1'b1;
    n = 0;
    while (ifc1.load_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (ifc1.load_ready !== 1'b1) check("one_start_timeout", 32'(ifc1.load_ready), 32'd1);
    start1 = 1'b0;
    ifc1.load_byte  = b;
    ifc1.load_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc1.load_valid = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (done1 !== 1'b1) check("one_done_timeout", 32'(done1), 32'd1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hb, gb, db, da, rbb;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    ifc0.load_valid = 1'b0;
    ifc0.load_byte  = '0;
    ifc1.load_valid = 1'b0;
    ifc1.load_byte  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ssel",     32'(ssel0), 32'd0);
    check("rst_sin",      32'(sin0), 32'd0);
    check("rst_busy",     32'(busy0), 32'd0);
    check("rst_done",     32'(done0), 32'd0);
    check("rst_ready",    32'(ifc0.load_ready), 32'd0);
    check("rst_rb_byte",  32'(ifc0.rb_byte), 32'd0);
    check("rst_rb_valid", 32'(ifc0.rb_valid), 32'd0);

    // Preload A0+k.
    rbb = rb_cnt;
    do_load(8'hA0, 1'b0, -1, -1);
    check("pre_rb_count", 32'(rb_cnt - rbb), 32'd32);
    check_pattern(8'hA0, 1'b0, "pre");

    // Streaming load of k.
    hb = hi_cnt; gb = gap_cnt; db = done_cnt; da = done_after; rbb = rb_cnt;
    do_load(8'h00, 1'b0, -1, -1);
    check("stream_ssel_cycles", 32'(hi_cnt - hb), 32'd256);
    check("stream_gaps",        32'(gap_cnt - gb), 32'd0);
    check("stream_done_count",  32'(done_cnt - db), 32'd1);
    check("stream_done_after",  32'(done_after - da), 32'd1);
    check("stream_rb_count",    32'(rb_cnt - rbb), 32'd32);
    check_rb(8'hA0, 1'b0, rbb, "stream");
    check_pattern(8'h00, 1'b0, "stream");

    // Reset in the middle of shifting, then reload.
    start0 = 1'b1;
    while (ifc0.load_ready !== 1'b1) @(negedge clk);
    start0 = 1'b0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_ssel", 32'(ssel0), 32'd1);
    rst_n = 1'b0;
    ifc0.load_valid = 1'b0;
    @(negedge clk);
    check("midrst_ssel_next", 32'(ssel0), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ssel",    32'(ssel0), 32'd0);
    check("midrst_busy",    32'(busy0), 32'd0);
    check("midrst_ready",   32'(ifc0.load_ready), 32'd0);
    check("midrst_rb_byte", 32'(ifc0.rb_byte), 32'd0);
    do_load(8'h00, 1'b0, -1, -1);
    check_pattern(8'h00, 1'b0, "reload");

    // Stall for five cycles after byte index 10.
    hb = hi_cnt; gb = gap_cnt; db = done_cnt; rbb = rb_cnt;
    do_load(8'h00, 1'b0, 10, -1);
    check("stall_ssel_cycles", 32'(hi_cnt - hb), 32'd256);
    check("stall_gap_cycles",  32'(gap_cnt - gb), 32'd6);
    check("stall_done_count",  32'(done_cnt - db), 32'd1);
    check("stall_rb_count",    32'(rb_cnt - rbb), 32'd32);
    check_rb(8'h00, 1'b0, rbb, "stall");
    check_pattern(8'h00, 1'b0, "stall");

    // start pulsed while busy must be ignored.
    hb = hi_cnt; db = done_cnt; rbb = rb_cnt;
    do_load(8'hF0, 1'b1, -1, 5);
    @(negedge clk);
    check("busy_done_width",  32'(done0), 32'd0);
    check("busy_idle",        32'(busy0), 32'd0);
    check("busy_done_count",  32'(done_cnt - db), 32'd1);
    check("busy_ssel_cycles", 32'(hi_cnt - hb), 32'd256);
    check("busy_rb_count",    32'(rb_cnt - rbb), 32'd32);
    check_rb(8'h00, 1'b0, rbb, "busy");
    check_pattern(8'hF0, 1'b1, "busy");

    // Back-to-back loads.
    rbb = rb_cnt;
    do_load(8'h00, 1'b0, -1, -1);
    check_rb(8'hF0, 1'b1, rbb, "b2b_first");
    db = done_cnt; rbb = rb_cnt;
    do_load(8'h55, 1'b0, -1, -1);
    check("b2b_done_count", 32'(done_cnt - db), 32'd1);
    check_rb(8'h00, 1'b0, rbb, "b2b_second");
    check_pattern(8'h55, 1'b0, "b2b");

    // Single-entry chain: bit order.
    load1(8'h81);
    check("one_sin_seq_81", 32'(sin_seq1), 32'h81);
    check("one_pat_81",     32'(chain1), 32'h81);
    load1(8'hC5);
    check("one_sin_seq_c5", 32'(sin_seq1), 32'hC5);
    check("one_pat_c5",     32'(chain1), 32'hC5);
    check("one_rb_81",      32'(ifc1.rb_byte), 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
